i2s_dac_tx: RTL

- Audio output end of the filter chain: accepts 27-bit signed 2.25 fixed-point stereo samples and converts each to 16-bit Q1.15 with saturation.
- Serializes the result to the codec DAC in I2S format, generating BCLK and DACLRCK from aud_clk.
- Issues a one-cycle sample_tick per frame; the filter/SOS enable uses it as its sample strobe.

---
 rtl/i2s_dac_tx.sv | 88 ++++++++
 1 files changed

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: converts signed 2.25 stereo samples to saturated Q1.15 and
// serializes them as I2S master (BCLK/DACLRCK from aud_clk) with a frame strobe.
module i2s_dac_tx #(
  parameter int BCLK_HALF = 3,
  parameter int OUT_W = 16
) (
  input  logic              aud_clk,
  input  logic              reset,
  input  logic [26:0]       in_l,
  input  logic [26:0]       in_r,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sample_tick,
  output logic              aud_bclk,
  output logic              aud_daclrck,
  output logic              aud_dacdat,
  output logic              sat,
  output logic [15:0]       underrun_cnt,
  input  logic              clr_status
);
  localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  logic [DW-1:0] div;
  logic [5:0] bitcnt, nxt_cnt;
  logic [4:0] slot;
  logic [26:0] hold_l, hold_r;
  logic [OUT_W-1:0] last_l, last_r, cnv_l, cnv_r, word;
  logic full, armed, wrap, fall, load, acc, sat_l, sat_r, dat;

  function automatic logic [OUT_W-1:0] conv(input logic [26:0] x);
    return (x[26] != x[25]) ? (x[26] ? 16'h8000 : 16'h7fff) : {x[26], x[24:10]};
  endfunction

  assign wrap = div == DW'(BCLK_HALF - 1);
  assign fall = wrap && aud_bclk;
  assign load = fall && bitcnt == 6'd63;
  assign in_ready = !full;
  assign acc = in_valid && !full;
  assign cnv_l = conv(hold_l);
  assign cnv_r = conv(hold_r);
  assign sat_l = hold_l[26] != hold_l[25];
  assign sat_r = hold_r[26] != hold_r[25];
  assign nxt_cnt = bitcnt + 6'd1;
  assign slot = nxt_cnt[4:0];
  assign word = nxt_cnt[5] ? last_r : last_l;
  // slot 0 carries the I2S one-bit delay; the word occupies slots 1..16
  assign dat = (slot != 5'd0 && slot <= 5'd16) ? word[4'(5'd16 - slot)] : 1'b0;

  always_ff @(posedge aud_clk) begin
    if (reset) begin
      div <= '0;
      aud_bclk <= 1'b0;
      bitcnt <= '1;
      aud_daclrck <= 1'b0;
      aud_dacdat <= 1'b0;
      sample_tick <= 1'b0;
      sat <= 1'b0;
      underrun_cnt <= '0;
      full <= 1'b0;
      armed <= 1'b0;
      last_l <= '0;
      last_r <= '0;
      hold_l <= '0;
      hold_r <= '0;
    end else begin
      div <= wrap ? '0 : div + 1'b1;
      if (wrap) aud_bclk <= !aud_bclk;
      sample_tick <= load;
      sat <= load && full && (sat_l || sat_r);
      if (fall) begin
        bitcnt <= nxt_cnt;
        aud_daclrck <= nxt_cnt[5];
        aud_dacdat <= dat;
      end
      if (acc) begin
        hold_l <= in_l;
        hold_r <= in_r;
      end
      full <= full ? !load : acc;
      if (load && full) begin
        last_l <= cnv_l;
        last_r <= cnv_r;
        armed <= 1'b1;
      end
      if (clr_status) underrun_cnt <= '0;
      else if (load && !full && armed && underrun_cnt != 16'hffff) underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
endmodule
